// File: rtl/stereo_frame_buffer.sv
// Ping-pong multi-channel frame store: the camera fills one bank while the matcher reads
// the other. Banks change owner on a completed frame (all channels' wlast) or on reader release.
`timescale 1ns/1ps
module stereo_frame_buffer #(
  parameter int CAMERA_HSIZE   = 32,
  parameter int CAMERA_VSIZE   = 16,
  parameter int PIXEL_SIZE     = 8,
  parameter int NUM_CH         = 2,
  parameter int BUF_ADDR_WIDTH = 10,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         buf_wvalid,
  output logic                         buf_wready,
  input  logic [CH_W-1:0]              buf_wch,
  input  logic [BUF_ADDR_WIDTH-1:0]    buf_waddr,
  input  logic [PIXEL_SIZE-1:0]        buf_wdata,
  input  logic                         buf_wlast,
  input  logic                         buf_rvalid,
  output logic                         buf_rready,
  input  logic [BUF_ADDR_WIDTH-1:0]    buf_raddr,
  output logic [NUM_CH*PIXEL_SIZE-1:0] buf_rdata,
  output logic                         buf_rdata_valid,
  input  logic                         rd_release,
  output logic                         frame_avail,
  output logic                         addr_err
);

  localparam int FRAME_PIXELS = CAMERA_HSIZE * CAMERA_VSIZE;
  localparam int DEPTH        = 2 ** (BUF_ADDR_WIDTH + 1);
  localparam logic [BUF_ADDR_WIDTH:0] FRAME_LIM = (BUF_ADDR_WIDTH + 1)'(FRAME_PIXELS);

  if (FRAME_PIXELS > 2 ** BUF_ADDR_WIDTH) begin : g_size_check
    $error("stereo_frame_buffer: frame does not fit in BUF_ADDR_WIDTH");
  end

  logic [PIXEL_SIZE-1:0] mem [NUM_CH][DEPTH];

  logic [1:0]                    bank_full_q, bank_full_d;
  logic                          wr_bank_q, wr_bank_d;
  logic                          rd_bank_q, rd_bank_d;
  logic [NUM_CH-1:0]             ch_last_q, ch_last_d;
  logic                          addr_err_q, addr_err_d;
  logic [NUM_CH*PIXEL_SIZE-1:0]  rdata_q, rdata_d;
  logic                          rvalid_q;

  logic              wr_acc, rd_acc, w_ch_ok, w_addr_ok, w_ok, r_addr_ok;
  logic              commit, release_go;
  logic [NUM_CH-1:0] wch_hit, ch_last_nxt;

  assign buf_wready  = ~bank_full_q[wr_bank_q];
  assign buf_rready  = bank_full_q[rd_bank_q];
  assign frame_avail = bank_full_q[rd_bank_q];
  assign buf_rdata       = rdata_q;
  assign buf_rdata_valid = rvalid_q;
  assign addr_err        = addr_err_q;

  assign wr_acc    = buf_wvalid & buf_wready;
  assign rd_acc    = buf_rvalid & buf_rready;
  assign w_ch_ok   = int'(buf_wch) < NUM_CH;
  assign w_addr_ok = {1'b0, buf_waddr} < FRAME_LIM;
  assign r_addr_ok = {1'b0, buf_raddr} < FRAME_LIM;
  assign w_ok      = w_ch_ok & w_addr_ok;

  always_comb begin
    wch_hit = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_ch_ok && buf_wch == CH_W'(k)) wch_hit[k] = 1'b1;
    end
  end

  // An out-of-range address still counts toward frame completion; a bad channel cannot.
  assign ch_last_nxt = ch_last_q | ((wr_acc & buf_wlast) ? wch_hit : '0);
  assign commit      = wr_acc & (&ch_last_nxt);
  assign release_go  = rd_release & bank_full_q[rd_bank_q];

  always_comb begin
    bank_full_d = bank_full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    ch_last_d   = ch_last_nxt;
    addr_err_d  = addr_err_q | (wr_acc & ~w_ok) | (rd_acc & ~r_addr_ok);
    rdata_d     = rdata_q;
    // Commit needs the fill bank empty, release needs the read bank full: never the same bank.
    if (commit) begin
      bank_full_d[wr_bank_q] = 1'b1;
      wr_bank_d              = ~wr_bank_q;
      ch_last_d              = '0;
    end
    if (release_go) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d              = ~rd_bank_q;
    end
    if (rd_acc) begin
      for (int k = 0; k < NUM_CH; k++) begin
        rdata_d[k*PIXEL_SIZE +: PIXEL_SIZE] =
          r_addr_ok ? mem[k][{rd_bank_q, buf_raddr}] : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full_q <= 2'b00;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      ch_last_q   <= '0;
      addr_err_q  <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      bank_full_q <= bank_full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      ch_last_q   <= ch_last_d;
      addr_err_q  <= addr_err_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rd_acc;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (wr_acc && w_ok && wch_hit[k]) mem[k][{wr_bank_q, buf_waddr}] <= buf_wdata;
    end
  end

endmodule
